// File: rtl/apb_slave_regfile.sv
// APB completer backed by a word-addressed register file.
// Ports: clk, rst (async low), PSEL/PEN/PW/PADDR/PWDATA in; PREADY/PRDATA/PSLVERR out.
module apb_slave_regfile #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int DEPTH       = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  PSEL,
  input  logic                  PEN,
  input  logic                  PW,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic                  PREADY,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PSLVERR
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic {IDLE, ACCESS} state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [IW-1:0]         addr_q;
  logic                  wr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic          cap;
  logic          we;
  logic          in_rng;
  logic [IW-1:0] idx;
  logic          rdy;

  assign idx    = PADDR[IW-1:0];
  assign in_rng = 32'(PADDR) < 32'(DEPTH);
  assign rdy    = (state_q == ACCESS) && (cnt_q == WS);

  // Outputs decode registered state only.
  assign PREADY  = rdy;
  assign PRDATA  = (rdy && !wr_q) ? rdata_q : '0;
  assign PSLVERR = rdy && err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap     = 1'b0;
    we      = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Access without a preceding setup is ignored.
        if (PSEL && !PEN) begin
          state_d = ACCESS;
          cnt_d   = '0;
          cap     = 1'b1;
        end
      end
      ACCESS: begin
        if (!(PSEL && PEN)) begin
          state_d = IDLE;
        end else if (rdy) begin
          state_d = IDLE;
          we      = wr_q && !err_q;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (cap) begin
        addr_q  <= idx;
        wr_q    <= PW;
        wdata_q <= PWDATA;
        err_q   <= !in_rng;
        rdata_q <= in_rng ? mem_q[idx] : '0;
      end
      if (we) begin
        mem_q[addr_q] <= wdata_q;
      end
    end
  end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Bench for apb_slave_regfile: three instances with 0, 3 and 2 wait states.
// Transaction-level model plus per-cycle compare and literal spot checks.
module tb_apb_slave_regfile;

  logic        clk;
  logic        rst_n  [3];
  logic        psel   [3];
  logic        pen    [3];
  logic        pw     [3];
  logic [7:0]  paddr  [3];
  logic [31:0] pwdata [3];
  logic        pready [3];
  logic [31:0] prdata [3];
  logic        pslverr[3];

  logic        exp_rdy[3];
  logic        exp_err[3];
  logic [31:0] exp_rd [3];

  logic [31:0] mdl [3][8];
  int          wsv [3];
  int          checks;
  int          errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  apb_slave_regfile #(.WAIT_STATES(0)) u0 (
    .clk(clk), .rst(rst_n[0]), .PSEL(psel[0]), .PEN(pen[0]),
    .PW(pw[0]), .PADDR(paddr[0]), .PWDATA(pwdata[0]),
    .PREADY(pready[0]), .PRDATA(prdata[0]), .PSLVERR(pslverr[0]));

  apb_slave_regfile #(.WAIT_STATES(3)) u1 (
    .clk(clk), .rst(rst_n[1]), .PSEL(psel[1]), .PEN(pen[1]),
    .PW(pw[1]), .PADDR(paddr[1]), .PWDATA(pwdata[1]),
    .PREADY(pready[1]), .PRDATA(prdata[1]), .PSLVERR(pslverr[1]));

  apb_slave_regfile #(.WAIT_STATES(2)) u2 (
    .clk(clk), .rst(rst_n[2]), .PSEL(psel[2]), .PEN(pen[2]),
    .PW(pw[2]), .PADDR(paddr[2]), .PWDATA(pwdata[2]),
    .PREADY(pready[2]), .PRDATA(prdata[2]), .PSLVERR(pslverr[2]));

  task automatic chk(string n, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", n, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("u%0d_PREADY", k), 32'(pready[k]), 32'(exp_rdy[k]));
      chk($sformatf("u%0d_PRDATA", k), prdata[k], exp_rd[k]);
      chk($sformatf("u%0d_PSLVERR", k), 32'(pslverr[k]), 32'(exp_err[k]));
    end
  end

  task automatic set_exp0(int k);
    exp_rdy[k] = 1'b0;
    exp_rd[k]  = '0;
    exp_err[k] = 1'b0;
  endtask

  task automatic idle(int k, int n);
    psel[k] = 1'b0;
    pen[k]  = 1'b0;
    set_exp0(k);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called at posedge+1. abort_at / rst_at name the access cycle index
  // at which PEN is dropped or reset is pulled (-1 = never).
  task automatic xfer(input int k, input bit wr, input int addr,
                      input logic [31:0] d, input int abort_at,
                      input int rst_at, output logic [31:0] rd,
                      output bit er, output int cyc);
    bit in_r;
    bit done;
    bit last;
    in_r = (addr < 8);
    done = 1'b0;
    rd   = '0;
    er   = 1'b0;
    cyc  = 1;
    psel[k]   = 1'b1;
    pen[k]    = 1'b0;
    pw[k]     = wr;
    paddr[k]  = addr[7:0];
    pwdata[k] = d;
    set_exp0(k);
    @(posedge clk);
    #1;
    for (int i = 0; i < 20 && !done; i++) begin
      cyc++;
      if (i == abort_at) begin
        pen[k] = 1'b0;
        set_exp0(k);
        @(posedge clk);
        #1;
        psel[k] = 1'b0;
        return;
      end
      pen[k]     = 1'b1;
      last       = (i == wsv[k]);
      exp_rdy[k] = last;
      exp_rd[k]  = (last && !wr && in_r) ? mdl[k][addr] : 32'h0;
      exp_err[k] = last && !in_r;
      #1;
      if (pready[k]) begin
        rd   = prdata[k];
        er   = pslverr[k];
        done = 1'b1;
      end
      if (i == rst_at) begin
        rst_n[k] = 1'b0;
        set_exp0(k);
        for (int j = 0; j < 8; j++) mdl[k][j] = '0;
        #1;
        chk("async_PREADY", 32'(pready[k]), 32'h0);
        chk("async_PRDATA", prdata[k], 32'h0);
        chk("async_PSLVERR", 32'(pslverr[k]), 32'h0);
        psel[k] = 1'b0;
        pen[k]  = 1'b0;
        @(posedge clk);
        #1;
        rst_n[k] = 1'b1;
        return;
      end
      @(posedge clk);
      if (done && wr && in_r) mdl[k][addr] = d;
      #1;
    end
    psel[k] = 1'b0;
    pen[k]  = 1'b0;
    set_exp0(k);
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL timeout u%0d addr %0d got no PREADY exp PREADY", k, addr);
    end
  endtask

  logic [31:0] rd;
  bit          er;
  int          cyc;

  initial begin
    checks = 0;
    errors = 0;
    wsv[0] = 0;
    wsv[1] = 3;
    wsv[2] = 2;
    for (int k = 0; k < 3; k++) begin
      rst_n[k]  = 1'b0;
      psel[k]   = 1'b0;
      pen[k]    = 1'b0;
      pw[k]     = 1'b0;
      paddr[k]  = '0;
      pwdata[k] = '0;
      set_exp0(k);
      for (int j = 0; j < 8; j++) mdl[k][j] = '0;
    end
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;
    idle(0, 1);

    // u0: zero wait states
    xfer(0, 1, 2, 32'hcafecafe, -1, -1, rd, er, cyc);
    chk("wr2_cycles", cyc, 2);
    chk("wr2_err", 32'(er), 0);
    xfer(0, 0, 2, 0, -1, -1, rd, er, cyc);
    chk("rd2_data", rd, 32'hcafecafe);
    chk("rd2_cycles", cyc, 2);
    xfer(0, 1, 1, 32'ha5a50001, -1, -1, rd, er, cyc);
    chk("b2b_wr_cycles", cyc, 2);
    xfer(0, 0, 1, 0, -1, -1, rd, er, cyc);
    chk("b2b_rd_data", rd, 32'ha5a50001);
    chk("b2b_rd_cycles", cyc, 2);
    xfer(0, 1, 9, 32'hdeadbeef, -1, -1, rd, er, cyc);
    chk("oob_wr_err", 32'(er), 1);
    for (int a = 0; a < 8; a++) begin
      xfer(0, 0, a, 0, -1, -1, rd, er, cyc);
    end
    xfer(0, 0, 2, 0, -1, -1, rd, er, cyc);
    chk("oob_keep2", rd, 32'hcafecafe);
    xfer(0, 0, 9, 0, -1, -1, rd, er, cyc);
    chk("oob_rd_data", rd, 32'h0);
    chk("oob_rd_err", 32'(er), 1);
    idle(0, 1);

    // u1: three wait states
    xfer(1, 1, 5, 32'h12345678, -1, -1, rd, er, cyc);
    chk("ws3_wr_cycles", cyc, 5);
    xfer(1, 0, 5, 0, -1, -1, rd, er, cyc);
    chk("ws3_rd_data", rd, 32'h12345678);
    chk("ws3_rd_cycles", cyc, 5);
    idle(1, 1);

    // u2: two wait states, aborted write
    xfer(2, 1, 4, 32'h11112222, -1, -1, rd, er, cyc);
    chk("ws2_wr_cycles", cyc, 4);
    xfer(2, 1, 4, 32'h33334444, 1, -1, rd, er, cyc);
    idle(2, 1);
    xfer(2, 0, 4, 0, -1, -1, rd, er, cyc);
    chk("abort_keep", rd, 32'h11112222);
    xfer(2, 1, 4, 32'h55556666, -1, -1, rd, er, cyc);
    chk("post_abort_cycles", cyc, 4);
    xfer(2, 0, 4, 0, -1, -1, rd, er, cyc);
    chk("post_abort_data", rd, 32'h55556666);
    idle(2, 1);

    // u1: reset during wait states of a write to addr 3
    xfer(1, 1, 3, 32'h77778888, -1, 1, rd, er, cyc);
    idle(1, 1);
    xfer(1, 0, 3, 0, -1, -1, rd, er, cyc);
    chk("rst_mem3", rd, 32'h0);
    xfer(1, 0, 5, 0, -1, -1, rd, er, cyc);
    chk("rst_mem5", rd, 32'h0);
    psel[1] = 1'b1;
    pen[1]  = 1'b1;
    set_exp0(1);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    idle(1, 1);

    // u0: reset while PREADY is high on a read
    xfer(0, 0, 2, 0, -1, 0, rd, er, cyc);
    idle(0, 1);
    xfer(0, 0, 2, 0, -1, -1, rd, er, cyc);
    chk("rst_mem2", rd, 32'h0);
    idle(0, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_slave_regfile.md
# apb_slave_regfile

APB completer with a word-addressed register file, answering the transfers issued by `APB_master`. It decodes setup and access phases and inserts a programmable number of wait states before asserting `PREADY`. Read data is returned on `PRDATA`, and writes are committed to the register file. Out-of-range addresses are flagged on `PSLVERR`. It replaces the behavioural memory model as the synthesizable slave end of the APB link.

## Interface
- `DATA_WIDTH`, 32: width of `PWDATA`, `PRDATA` and each register.
- `ADDR_WIDTH`, 8: width of `PADDR`.
- `DEPTH`, 8: number of registers; `PADDR` indexes words directly (no byte offset).
- `WAIT_STATES`, 0: access cycles with `PREADY` low before completion; legal range 0..15.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous and active-low.
- `PSEL` in 1: slave select from master.
- `PEN` in 1: enable; access phase when high with `PSEL`.
- `PW` in 1: 1 = write, 0 = read.
- `PADDR` in `ADDR_WIDTH`: word address.
- `PWDATA` in `DATA_WIDTH`: write data.
- `PREADY` out 1: transfer completes in a cycle where `PSEL`, `PEN` and `PREADY` are all high.
- `PRDATA` out `DATA_WIDTH`: read data, valid when `PREADY` is high on a read; 0 otherwise.
- `PSLVERR` out 1: error flag, valid only while `PREADY` is high; high when `PADDR >= DEPTH`.

## Operation
- States:
  - IDLE.
  - ACCESS, with a wait counter `cnt`, 4 bits.
  - Captured transfer registers `a_addr`, `a_wr`, `a_wdata`, `rdata`, `err`.
- IDLE → ACCESS on a sampled edge with `PSEL`=1 and `PEN`=0 (setup phase). On that edge:
  - capture `PADDR`, `PW` and `PWDATA`;
  - `cnt` ← 0;
  - `err` ← (`PADDR >= DEPTH`);
  - `rdata` ← `mem[PADDR]` if in range, else 0.
- IDLE with `PEN`=1 (access without setup) is ignored: stay in IDLE, `PREADY` stays 0.
- In ACCESS, `PREADY` = (`cnt == WAIT_STATES`), decoded from registers. Each edge with `PSEL`&`PEN` high and `PREADY` low increments `cnt`.
- Completion edge (ACCESS, `PSEL`&`PEN`&`PREADY`):
  - if `a_wr` and not `err`, `mem[a_addr]` ← `a_wdata`;
  - an out-of-range write is discarded;
  - the state returns to IDLE.
- Abort: in ACCESS, if `PSEL`=0 or `PEN`=0 is sampled before completion, go to IDLE with no write and no error.
- Outputs:
  - `PRDATA` = `rdata` when `PREADY`&!`a_wr`, else 0.
  - `PSLVERR` = `err`&`PREADY`.
- Back-to-back transfers: after completion the master may present the next setup immediately. It is sampled on the next edge with no extra idle cycle required.
- Read-after-write to the same address in the following transfer returns the new value, because the write commits before the next setup is sampled.
- Reset (`rst` low, asynchronous):
  - state → IDLE, `cnt` → 0;
  - `rdata`, `err`, all captured registers and all `mem` words → 0;
  - `PREADY`, `PSLVERR` and `PRDATA` go to 0 immediately.
- Reset mid-transfer abandons the transfer; a pending write is not committed.

## Timing
- Cycle S (setup sampled) → ACCESS. `PREADY` is high in cycle S+1+`WAIT_STATES`.
- Minimum transfer is 2 cycles (setup + access) with `WAIT_STATES`=0.
- Write data is visible in `mem` from the edge ending the completion cycle.
- `PREADY`, `PRDATA` and `PSLVERR` are combinational decodes of registered state only; there is no path from inputs to outputs.

## Test plan
- Reset, `WAIT_STATES`=0:
  - write `32'hcafecafe` to addr 2 → `PREADY` high in the first access cycle, `PSLVERR`=0;
  - then read addr 2 → `PRDATA`=`32'hcafecafe` with `PREADY`.
- `WAIT_STATES`=3, read addr 5 after writing `32'h12345678`:
  - `PREADY` is low for exactly 3 access cycles, then high for 1;
  - `PRDATA` is 0 until `PREADY` rises, then `32'h12345678`.
- Out-of-range address 9 with `DEPTH`=8:
  - write `32'hdeadbeef` → `PSLVERR`=1 with `PREADY`; `mem` is unchanged (all reads of 0..7 still return their previous values);
  - read 9 → `PRDATA`=0, `PSLVERR`=1.
- Back-to-back write addr 1 then read addr 1 with no idle cycle → read returns the new data. Each transfer takes exactly 2+`WAIT_STATES` cycles.
- Aborted write: `WAIT_STATES`=2, drop `PEN` after 1 access cycle → state returns to IDLE, `mem[addr]` is unchanged, and the next transfer completes normally.
- Reset asserted in the middle of the wait states of a write to addr 3 → outputs go to 0 asynchronously. After release, `mem[3]` reads 0, and `PEN` without setup is ignored (`PREADY` stays 0).
